// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states,
// opcode/funct constants, datapath select codes and the instruction class bundle.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] EOP_SIGN = 2'b00;
    localparam logic [1:0] EOP_ZERO = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_SH2  = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    // One-hot instruction class; rsub qualifies rtype_alu (subu vs addu).
    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic illegal;
        logic rsub;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier; anything outside the supported
// subset (including the all-zero nop) lands in the illegal class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: cls.rtype_alu = 1'b1;
                    FN_SUBU: begin
                        cls.rtype_alu = 1'b1;
                        cls.rsub      = 1'b1;
                    end
                    FN_JR:   cls.jr = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore controller: FETCH/DECODE/EXEC/MEM/WB sequencing and all
// datapath strobes/selects. Define MC_CTRL_INSTRET_EN to build the retire counter.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RFWr,
    output logic        DMWr,
    output logic        mem_req,
    output logic [1:0]  EOp,
    output logic [2:0]  ALUOp,
    output logic        ALUSrc,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic [1:0]  NPCOp,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    iclass_t cls;
    state_t  state_q, state_d;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = (cls.j || cls.jal || cls.jr || cls.illegal) ? FETCH : EXEC;
            EXEC: begin
                if (cls.beq)                 state_d = FETCH;
                else if (cls.lw || cls.sw)   state_d = MEM;
                else                         state_d = WB;
            end
            MEM: if (mem_ready) state_d = cls.lw ? WB : FETCH;
            WB:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Strobes are gated by reset so nothing fires while it is held low.
    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        mem_req = 1'b0;
        EOp     = EOP_SIGN;
        ALUOp   = ALU_ADD;
        ALUSrc  = 1'b0;
        RegDst  = RD_RT;
        WDSel   = WD_ALU;
        NPCOp   = NPC_PC4;
        if (reset) begin
            // EXEC selects stay applied through MEM/WB to keep address/result stable.
            if (state_q == EXEC || state_q == MEM || state_q == WB) begin
                if (cls.beq) begin
                    ALUOp = ALU_SUB;
                    EOp   = EOP_SH2;
                end else if (cls.rtype_alu) begin
                    ALUOp = cls.rsub ? ALU_SUB : ALU_ADD;
                end else if (cls.ori) begin
                    EOp    = EOP_ZERO;
                    ALUSrc = 1'b1;
                    ALUOp  = ALU_OR;
                end else if (cls.lui) begin
                    EOp    = EOP_LUI;
                    ALUSrc = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    ALUSrc = 1'b1;
                end
            end
            unique case (state_q)
                FETCH: begin
                    IRWr = 1'b1;
                    PCWr = 1'b1;
                end
                DECODE: begin
                    if (cls.j || cls.jal) begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_J;
                    end
                    if (cls.jal) begin
                        RFWr   = 1'b1;
                        RegDst = RD_RA;
                        WDSel  = WD_PC;
                    end
                    if (cls.jr) begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_RS;
                    end
                end
                EXEC: begin
                    if (cls.beq) begin
                        PCWr  = zero;
                        NPCOp = NPC_BR;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    DMWr    = cls.sw;
                end
                WB: begin
                    RFWr   = 1'b1;
                    RegDst = cls.rtype_alu ? RD_RD : RD_RT;
                    WDSel  = cls.lw ? WD_DM : WD_ALU;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (state_q != FETCH) && (state_d == FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
